tour_seq: RTL and testbench
===========================

TOUR_SEQ -- requirements
Module: tour_seq

Interface
REQ-001 Parameter BOARD_DIM, default 5, board side length in squares (legal 3..8).
REQ-002 Parameter MV_W, default 5, mv_indx width; SHALL equal clog2(BOARD_DIM*BOARD_DIM).
REQ-003 Parameter RESP_DONE, default 8'hA5, response byte for final/standalone completion.
REQ-004 Parameter RESP_PROG, default 8'h5A, response byte for intermediate tour completion.
REQ-005 clk  input  1  system clock; all state updates on rising edge.
REQ-006 rst  input  1  reset; synchronous and active-high.
REQ-007 start_tour  input  1  one-cycle pulse: solved tour ready, begin sequencing.
REQ-008 move  input  8  one-hot knight move addressed by mv_indx.
REQ-009 mv_indx  output  MV_W  index of current tour move.
REQ-010 cmd_UART / cmd_rdy_UART  input  16 / 1  command and ready from BLE UART.
REQ-011 cmd / cmd_rdy  output  16 / 1  multiplexed command and ready to command processor.
REQ-012 clr_cmd_rdy  input  1  command processor accepted cmd.
REQ-013 send_resp  input  1  command processor finished current command.
REQ-014 resp  output  8  response byte for UART.
REQ-015 tour_active / err  output  1 / 1  sequencing in progress / one-cycle invalid-move pulse.

Function
REQ-016 States: IDLE, VERT, WAIT_V, HORZ, WAIT_H.
REQ-017 IDLE: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART (combinational passthrough), resp=RESP_DONE, tour_active=0.
REQ-018 IDLE & start_tour: next cycle state=VERT, mv_indx=0, tour_active=1.
REQ-019 Move decode (dx,dy): bit0(+1,+2) bit1(-1,+2) bit2(-2,+1) bit3(-2,-1) bit4(-1,-2) bit5(+1,-2) bit6(+2,-1) bit7(+2,+1).
REQ-020 Command format: cmd[15:12] opcode, cmd[11:4] heading, cmd[3:0] square count.
REQ-021 VERT: cmd={4'h2, dy>0?8'h00:8'hFF, |dy|}; cmd_rdy=1 registered, asserted first cycle in VERT.
REQ-022 HORZ: cmd={4'h3, dx>0?8'hBF:8'h3F, |dx|}; cmd_rdy=1 registered, asserted first cycle in HORZ.
REQ-023 cmd_rdy in VERT/HORZ SHALL hold until clr_cmd_rdy; clr_cmd_rdy moves VERT->WAIT_V, HORZ->WAIT_H and drops cmd_rdy next cycle.
REQ-024 WAIT_V & send_resp -> HORZ; resp=RESP_PROG during WAIT_V.
REQ-025 WAIT_H & send_resp: if mv_indx==BOARD_DIM*BOARD_DIM-2 -> IDLE, else mv_indx+1 and -> VERT.
REQ-026 resp in WAIT_H SHALL be RESP_DONE when mv_indx is last index, else RESP_PROG, valid in the send_resp cycle.
REQ-027 send_resp in VERT/HORZ (before clr_cmd_rdy) SHALL be ignored.
REQ-028 Non-one-hot move sampled on entering VERT: err pulses 1 cycle, state->IDLE, no cmd_rdy issued.
REQ-029 start_tour outside IDLE SHALL be ignored.
REQ-030 mv_indx SHALL never exceed BOARD_DIM*BOARD_DIM-2; no wrap.
REQ-031 cmd_rdy_UART outside IDLE SHALL not reach cmd_rdy (unless REQ-036).

Reset
REQ-032 rst SHALL force IDLE, mv_indx=0, registered cmd_rdy=0, err=0, tour_active=0 on next clk edge.
REQ-033 rst mid-tour SHALL abandon the tour; no resumption without new start_tour.
REQ-034 After reset resp=RESP_DONE and cmd equals cmd_UART.

Configuration
REQ-035 Macro TOUR_SEQ_ABORT_EN selects UART abort.
REQ-036 Defined: cmd_rdy_UART in WAIT_V or WAIT_H forces IDLE next cycle, err pulses, UART cmd then passes through per REQ-017.
REQ-037 Undefined: UART commands during a tour are ignored; tour always runs to completion or reset.

Verification
REQ-038 BOARD_DIM=5, start_tour, move=8'h01 at indx0 -> cmd=16'h2002 then 16'h3BF1, resp=8'h5A on each send_resp.
REQ-039 Full 24-move tour with send_resp after each clr -> 48 cmd_rdy rises, final resp=8'hA5, mv_indx=23, tour_active=0.
REQ-040 move=8'h03 at entry to VERT -> err=1 for one cycle, state IDLE, cmd_rdy stays 0.
REQ-041 rst asserted in WAIT_H at mv_indx=7 -> next cycle mv_indx=0, cmd_rdy=0, tour_active=0.
REQ-042 IDLE, cmd_UART=16'h2001, cmd_rdy_UART=1 -> cmd=16'h2001, cmd_rdy=1 same cycle, resp=8'hA5.
REQ-043 TOUR_SEQ_ABORT_EN defined, cmd_rdy_UART=1 in WAIT_V -> IDLE next cycle, err pulse; undefined -> no state change.

Source files
------------

// File: rtl/tour_seq.sv
// Knight's-tour move sequencer: turns each one-hot move into a vertical then a horizontal
// drive command and muxes the command path with the BLE UART. Optional macro: TOUR_SEQ_ABORT_EN.
module tour_seq #(
    parameter int         BOARD_DIM = 5,
    parameter int         MV_W      = 5,
    parameter logic [7:0] RESP_DONE = 8'hA5,
    parameter logic [7:0] RESP_PROG = 8'h5A
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_tour,
    input  logic [7:0]      move,
    output logic [MV_W-1:0] mv_indx,
    input  logic [15:0]     cmd_UART,
    input  logic            cmd_rdy_UART,
    output logic [15:0]     cmd,
    output logic            cmd_rdy,
    input  logic            clr_cmd_rdy,
    input  logic            send_resp,
    output logic [7:0]      resp,
    output logic            tour_active,
    output logic            err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] VERT   = 3'd1;
    localparam logic [2:0] WAIT_V = 3'd2;
    localparam logic [2:0] HORZ   = 3'd3;
    localparam logic [2:0] WAIT_H = 3'd4;

    localparam logic [MV_W-1:0] LAST_IDX = MV_W'(BOARD_DIM * BOARD_DIM - 2);

    logic [2:0]        state;
    logic              cmd_rdy_r;
    logic              move_ok;
    logic              last_move;
    logic signed [2:0] dx;
    logic signed [2:0] dy;
    logic [15:0]       vert_cmd;
    logic [15:0]       horz_cmd;

    // Returns {dx, dy}; anything that is not one-hot decodes to zero displacement.
    function automatic logic [5:0] decode_move(input logic [7:0] m);
        case (m)
            8'h01:   return {3'sd1,  3'sd2};
            8'h02:   return {-3'sd1, 3'sd2};
            8'h04:   return {-3'sd2, 3'sd1};
            8'h08:   return {-3'sd2, -3'sd1};
            8'h10:   return {-3'sd1, -3'sd2};
            8'h20:   return {3'sd1,  -3'sd2};
            8'h40:   return {3'sd2,  -3'sd1};
            8'h80:   return {3'sd2,  3'sd1};
            default: return 6'd0;
        endcase
    endfunction

    function automatic logic [15:0] fmt_cmd(input logic [3:0] op, input logic signed [2:0] d,
                                            input logic [7:0] hd_pos, input logic [7:0] hd_neg);
        logic signed [2:0] mag;
        mag = (d < 0) ? -d : d;
        return {op, (d > 0) ? hd_pos : hd_neg, 1'b0, mag};
    endfunction

    assign {dx, dy}    = decode_move(move);
    assign move_ok     = (move != 8'h00) && ((move & (move - 8'h01)) == 8'h00);
    assign last_move   = (mv_indx == LAST_IDX);
    assign vert_cmd    = fmt_cmd(4'h2, dy, 8'h00, 8'hFF);
    assign horz_cmd    = fmt_cmd(4'h3, dx, 8'hBF, 8'h3F);
    assign tour_active = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mv_indx   <= '0;
            cmd_rdy_r <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_tour) begin
                        state     <= VERT;
                        mv_indx   <= '0;
                        cmd_rdy_r <= 1'b1;
                    end
                end
                VERT: begin
                    // The move for this index only becomes valid once mv_indx has settled here.
                    if (!move_ok) begin
                        state     <= IDLE;
                        cmd_rdy_r <= 1'b0;
                        err       <= 1'b1;
                    end else if (clr_cmd_rdy) begin
                        state     <= WAIT_V;
                        cmd_rdy_r <= 1'b0;
                    end
                end
                WAIT_V: begin
`ifdef TOUR_SEQ_ABORT_EN
                    if (cmd_rdy_UART) begin
                        state <= IDLE;
                        err   <= 1'b1;
                    end else
`endif
                    if (send_resp) begin
                        state     <= HORZ;
                        cmd_rdy_r <= 1'b1;
                    end
                end
                HORZ: begin
                    if (clr_cmd_rdy) begin
                        state     <= WAIT_H;
                        cmd_rdy_r <= 1'b0;
                    end
                end
                WAIT_H: begin
`ifdef TOUR_SEQ_ABORT_EN
                    if (cmd_rdy_UART) begin
                        state <= IDLE;
                        err   <= 1'b1;
                    end else
`endif
                    if (send_resp) begin
                        if (last_move) begin
                            state <= IDLE;
                        end else begin
                            state     <= VERT;
                            mv_indx   <= mv_indx + MV_W'(1);
                            cmd_rdy_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_rdy_r <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        cmd     = cmd_UART;
        cmd_rdy = cmd_rdy_UART;
        resp    = RESP_DONE;
        case (state)
            VERT: begin
                cmd     = vert_cmd;
                cmd_rdy = cmd_rdy_r & move_ok;
                resp    = RESP_PROG;
            end
            WAIT_V: begin
                cmd     = vert_cmd;
                cmd_rdy = 1'b0;
                resp    = RESP_PROG;
            end
            HORZ: begin
                cmd     = horz_cmd;
                cmd_rdy = cmd_rdy_r;
                resp    = RESP_PROG;
            end
            WAIT_H: begin
                cmd     = horz_cmd;
                cmd_rdy = 1'b0;
                resp    = last_move ? RESP_DONE : RESP_PROG;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tour_seq.sv
// Directed self-checking bench for tour_seq (BOARD_DIM=5); move at index i is one-hot bit i%8.
module tb_tour_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_tour;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;
    logic        tour_active;
    logic        err;

    logic        bad_mode = 1'b0;
    int          total = 0;
    int          bad = 0;
    int          rise_cnt = 0;
    logic        cmd_rdy_q = 1'b0;

    tour_seq #(.BOARD_DIM(5), .MV_W(5), .RESP_DONE(8'hA5), .RESP_PROG(8'h5A)) dut (
        .clk(clk), .rst(rst), .start_tour(start_tour), .move(move), .mv_indx(mv_indx),
        .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp),
        .tour_active(tour_active), .err(err)
    );

    always #5 clk = ~clk;

    // Solved-tour memory stand-in: combinational lookup on mv_indx.
    assign move = bad_mode ? 8'h03 : (8'h01 << mv_indx[2:0]);

    always @(posedge clk) begin
        cmd_rdy_q <= cmd_rdy;
        if (cmd_rdy && !cmd_rdy_q && tour_active) rise_cnt <= rise_cnt + 1;
    end

    // Hand-derived commands for move bit k: vertical then horizontal.
    function automatic logic [15:0] vexp(input int k);
        case (k)
            0: return 16'h2002;  1: return 16'h2002;  2: return 16'h2001;  3: return 16'h2FF1;
            4: return 16'h2FF2;  5: return 16'h2FF2;  6: return 16'h2FF1;  default: return 16'h2001;
        endcase
    endfunction

    function automatic logic [15:0] hexp(input int k);
        case (k)
            0: return 16'h3BF1;  1: return 16'h33F1;  2: return 16'h33F2;  3: return 16'h33F2;
            4: return 16'h33F1;  5: return 16'h3BF1;  6: return 16'h3BF2;  default: return 16'h3BF2;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_tour = 1'b1;
        step();
        start_tour = 1'b0;
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    // Expects to be in VERT for move i; leaves the DUT in HORZ.
    task automatic do_vert(input int i);
        total++; if (cmd_rdy !== 1'b1) begin bad++; $display("FAIL vert_rdy[%0d]: got %b want 1", i, cmd_rdy); end
        total++; if (cmd !== vexp(i % 8)) begin bad++; $display("FAIL vert_cmd[%0d]: got %h want %h", i, cmd, vexp(i % 8)); end
        total++; if (mv_indx !== 5'(i)) begin bad++; $display("FAIL mv_indx[%0d]: got %0d want %0d", i, mv_indx, i); end
        clr_cmd_rdy = 1'b1;
        step();
        clr_cmd_rdy = 1'b0;
        #1;
        total++; if (cmd_rdy !== 1'b0) begin bad++; $display("FAIL wait_v_rdy[%0d]: got %b want 0", i, cmd_rdy); end
        total++; if (resp !== 8'h5A) begin bad++; $display("FAIL wait_v_resp[%0d]: got %h want 5a", i, resp); end
        send_resp = 1'b1;
        step();
        send_resp = 1'b0;
        #1;
    endtask

    // Expects to be in HORZ for move i; leaves the DUT in WAIT_H.
    task automatic do_horz(input int i);
        total++; if (cmd_rdy !== 1'b1) begin bad++; $display("FAIL horz_rdy[%0d]: got %b want 1", i, cmd_rdy); end
        total++; if (cmd !== hexp(i % 8)) begin bad++; $display("FAIL horz_cmd[%0d]: got %h want %h", i, cmd, hexp(i % 8)); end
        clr_cmd_rdy = 1'b1;
        step();
        clr_cmd_rdy = 1'b0;
        #1;
        total++;
        if (resp !== ((i == 23) ? 8'hA5 : 8'h5A)) begin
            bad++; $display("FAIL wait_h_resp[%0d]: got %h want %h", i, resp, (i == 23) ? 8'hA5 : 8'h5A);
        end
    endtask

    task automatic finish_h();
        send_resp = 1'b1;
        step();
        send_resp = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        cmd_UART = 16'h1234;
        apply_reset();
        total++; if (mv_indx !== 5'd0) begin bad++; $display("FAIL rst_indx: got %0d want 0", mv_indx); end
        total++; if (cmd_rdy !== 1'b0) begin bad++; $display("FAIL rst_rdy: got %b want 0", cmd_rdy); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err); end
        total++; if (tour_active !== 1'b0) begin bad++; $display("FAIL rst_active: got %b want 0", tour_active); end
        total++; if (resp !== 8'hA5) begin bad++; $display("FAIL rst_resp: got %h want a5", resp); end
        total++; if (cmd !== 16'h1234) begin bad++; $display("FAIL rst_cmd: got %h want 1234", cmd); end
    endtask

    task automatic test_idle_passthru();
        cmd_UART = 16'h2001;
        cmd_rdy_UART = 1'b1;
        #1;
        total++; if (cmd !== 16'h2001) begin bad++; $display("FAIL idle_cmd: got %h want 2001", cmd); end
        total++; if (cmd_rdy !== 1'b1) begin bad++; $display("FAIL idle_rdy: got %b want 1", cmd_rdy); end
        total++; if (resp !== 8'hA5) begin bad++; $display("FAIL idle_resp: got %h want a5", resp); end
        cmd_rdy_UART = 1'b0;
        step();
    endtask

    task automatic test_full_tour();
        int base;
        base = rise_cnt;
        pulse_start();
        total++; if (tour_active !== 1'b1) begin bad++; $display("FAIL tour_active: got %b want 1", tour_active); end
        // send_resp before clr_cmd_rdy must not advance
        send_resp = 1'b1;
        step();
        send_resp = 1'b0;
        #1;
        total++; if (cmd !== 16'h2002 || cmd_rdy !== 1'b1) begin bad++; $display("FAIL early_resp: got %h/%b want 2002/1", cmd, cmd_rdy); end
        for (int i = 0; i < 24; i++) begin
            do_vert(i);
            if (i == 2) begin
                start_tour = 1'b1;
                step();
                start_tour = 1'b0;
                #1;
                total++; if (mv_indx !== 5'd2 || cmd !== hexp(2)) begin bad++; $display("FAIL restart_ignored: got %0d/%h want 2/%h", mv_indx, cmd, hexp(2)); end
            end
            do_horz(i);
            finish_h();
        end
        step();
        total++; if (rise_cnt - base !== 48) begin bad++; $display("FAIL rdy_rises: got %0d want 48", rise_cnt - base); end
        total++; if (mv_indx !== 5'd23) begin bad++; $display("FAIL end_indx: got %0d want 23", mv_indx); end
        total++; if (tour_active !== 1'b0) begin bad++; $display("FAIL end_active: got %b want 0", tour_active); end
        total++; if (resp !== 8'hA5) begin bad++; $display("FAIL end_resp: got %h want a5", resp); end
    endtask

    task automatic test_bad_move();
        bad_mode = 1'b1;
        pulse_start();
        total++; if (cmd_rdy !== 1'b0) begin bad++; $display("FAIL bad_rdy: got %b want 0", cmd_rdy); end
        step();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL bad_err: got %b want 1", err); end
        total++; if (tour_active !== 1'b0) begin bad++; $display("FAIL bad_idle: got %b want 0", tour_active); end
        total++; if (cmd_rdy !== 1'b0) begin bad++; $display("FAIL bad_rdy2: got %b want 0", cmd_rdy); end
        step();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL bad_err_len: got %b want 0", err); end
        bad_mode = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            do_vert(i);
            do_horz(i);
            finish_h();
        end
        do_vert(7);
        do_horz(7);
        apply_reset();
        total++; if (mv_indx !== 5'd0) begin bad++; $display("FAIL mid_rst_indx: got %0d want 0", mv_indx); end
        total++; if (cmd_rdy !== 1'b0) begin bad++; $display("FAIL mid_rst_rdy: got %b want 0", cmd_rdy); end
        total++; if (tour_active !== 1'b0) begin bad++; $display("FAIL mid_rst_active: got %b want 0", tour_active); end
        step();
        step();
        total++; if (tour_active !== 1'b0) begin bad++; $display("FAIL no_resume: got %b want 0", tour_active); end
    endtask

    task automatic test_uart_in_wait();
        apply_reset();
        pulse_start();
        clr_cmd_rdy = 1'b1;
        step();
        clr_cmd_rdy = 1'b0;
        cmd_UART = 16'h2001;
        cmd_rdy_UART = 1'b1;
        #1;
        total++; if (cmd_rdy !== 1'b0) begin bad++; $display("FAIL wait_uart_rdy: got %b want 0", cmd_rdy); end
        step();
`ifdef TOUR_SEQ_ABORT_EN
        total++; if (tour_active !== 1'b0) begin bad++; $display("FAIL abort_idle: got %b want 0", tour_active); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL abort_err: got %b want 1", err); end
        total++; if (cmd !== 16'h2001 || cmd_rdy !== 1'b1) begin bad++; $display("FAIL abort_pass: got %h/%b want 2001/1", cmd, cmd_rdy); end
`else
        total++; if (tour_active !== 1'b1) begin bad++; $display("FAIL uart_ignored: got %b want 1", tour_active); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL uart_err: got %b want 0", err); end
        total++; if (cmd !== 16'h2002 || cmd_rdy !== 1'b0 || resp !== 8'h5A) begin
            bad++; $display("FAIL uart_hold: got %h/%b/%h want 2002/0/5a", cmd, cmd_rdy, resp);
        end
`endif
        cmd_rdy_UART = 1'b0;
        apply_reset();
    endtask

    initial begin
        rst = 1'b1;
        start_tour = 1'b0;
        cmd_UART = 16'h0000;
        cmd_rdy_UART = 1'b0;
        clr_cmd_rdy = 1'b0;
        send_resp = 1'b0;
        step();
        test_reset();
        test_idle_passthru();
        test_full_tour();
        test_bad_move();
        test_reset_mid();
        test_uart_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
